// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM word controller.
package sram_pkg;

   localparam int SRAM_AW     = 18;
   localparam int SRAM_DW     = 16;
   localparam int ACC_CYC_MAX = 15;
   localparam int CNT_W       = $clog2(ACC_CYC_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_LO,
      ST_RD_HI,
      ST_WR_SETUP,
      ST_WR_STROBE,
      ST_WR_HOLD,
      ST_DONE
   } state_t;

   // Halfword address on the SRAM pins: word index plus half select.
   function automatic logic [SRAM_AW-1:0] half_addr(input logic [15:0] word, input logic half);
      return {1'b0, word, half};
   endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter timing one SRAM strobe phase; last is high on the final cycle.
module sram_phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             last
);

   logic [CNT_W-1:0] cnt_reg;

   // Reload wins over counting so back-to-back phases need no idle cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign last = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/sram_word_ctrl.sv
// Splits 32-bit LSU requests into one or two 16-bit asynchronous SRAM accesses.
module sram_word_ctrl
   import sram_pkg::*;
#(
   parameter int ACC_CYC = 2,
   parameter int ADDR_W  = 18
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [ADDR_W-1:0]  i_ADDR,
   input  logic [31:0]        i_WDATA,
   input  logic [3:0]         i_BMASK,
   input  logic               i_WREN,
   input  logic               i_RDEN,
   output logic [31:0]        o_RDATA,
   output logic               o_ACK,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic               SRAM_CE_N,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_UB_N
);

   state_t               state_reg;
   logic                 half_reg;
   logic [15:0]          word_reg;
   logic [31:0]          wdata_reg;
   logic [3:0]           mask_reg;
   logic [15:0]          rdata_lo_reg;
   logic [SRAM_DW-1:0]   dq_out_reg;
   logic                 dq_oe_reg;
   logic                 timer_load;
   logic                 timer_last;
   logic                 start_half;
   logic                 addr_lsb_unused;

   // Byte offset within the word carries no information for word accesses.
   assign addr_lsb_unused = ^i_ADDR[1:0];

   // A write whose low two mask bits are clear starts directly on the high half.
   assign start_half = (i_BMASK[1:0] == 2'b00);

   assign SRAM_DQ = dq_oe_reg ? dq_out_reg : {SRAM_DW{1'bz}};

   // Load the phase timer on every edge that enters a timed state.
   always_comb begin
      timer_load = 1'b0;
      case (state_reg)
         ST_IDLE:     timer_load = !i_WREN && i_RDEN;
         ST_RD_LO:    timer_load = timer_last;
         ST_WR_SETUP: timer_load = 1'b1;
         default:     timer_load = 1'b0;
      endcase
   end

   sram_phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (i_clk),
      .reset    (i_reset),
      .load     (timer_load),
      .load_val (CNT_W'(ACC_CYC)),
      .last     (timer_last)
   );

   // Transaction FSM; every SRAM pin and response output is a register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg    <= ST_IDLE;
         half_reg     <= 1'b0;
         word_reg     <= '0;
         wdata_reg    <= '0;
         mask_reg     <= '0;
         rdata_lo_reg <= '0;
         dq_out_reg   <= '0;
         dq_oe_reg    <= 1'b0;
         o_RDATA      <= '0;
         o_ACK        <= 1'b0;
         SRAM_ADDR    <= '0;
         SRAM_CE_N    <= 1'b1;
         SRAM_WE_N    <= 1'b1;
         SRAM_OE_N    <= 1'b1;
         SRAM_LB_N    <= 1'b1;
         SRAM_UB_N    <= 1'b1;
      end else begin
         o_ACK <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (i_WREN) begin
                  word_reg  <= i_ADDR[17:2];
                  wdata_reg <= i_WDATA;
                  mask_reg  <= i_BMASK;
                  if (i_BMASK == 4'b0000) begin
                     o_ACK     <= 1'b1;
                     state_reg <= ST_DONE;
                  end else begin
                     half_reg   <= start_half;
                     SRAM_ADDR  <= half_addr(i_ADDR[17:2], start_half);
                     dq_out_reg <= start_half ? i_WDATA[31:16] : i_WDATA[15:0];
                     dq_oe_reg  <= 1'b1;
                     SRAM_CE_N  <= 1'b0;
                     SRAM_WE_N  <= 1'b1;
                     state_reg  <= ST_WR_SETUP;
                  end
               end else if (i_RDEN) begin
                  word_reg  <= i_ADDR[17:2];
                  SRAM_ADDR <= half_addr(i_ADDR[17:2], 1'b0);
                  dq_oe_reg <= 1'b0;
                  SRAM_CE_N <= 1'b0;
                  SRAM_OE_N <= 1'b0;
                  SRAM_LB_N <= 1'b0;
                  SRAM_UB_N <= 1'b0;
                  state_reg <= ST_RD_LO;
               end
            end
            ST_RD_LO: begin
               if (timer_last) begin
                  rdata_lo_reg <= SRAM_DQ;
                  SRAM_ADDR    <= half_addr(word_reg, 1'b1);
                  state_reg    <= ST_RD_HI;
               end
            end
            ST_RD_HI: begin
               if (timer_last) begin
                  o_RDATA   <= {SRAM_DQ, rdata_lo_reg};
                  o_ACK     <= 1'b1;
                  SRAM_CE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  SRAM_LB_N <= 1'b1;
                  SRAM_UB_N <= 1'b1;
                  state_reg <= ST_DONE;
               end
            end
            ST_WR_SETUP: begin
               SRAM_WE_N <= 1'b0;
               SRAM_LB_N <= ~(half_reg ? mask_reg[2] : mask_reg[0]);
               SRAM_UB_N <= ~(half_reg ? mask_reg[3] : mask_reg[1]);
               state_reg <= ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
               if (timer_last) begin
                  SRAM_WE_N <= 1'b1;
                  state_reg <= ST_WR_HOLD;
               end
            end
            ST_WR_HOLD: begin
               SRAM_LB_N <= 1'b1;
               SRAM_UB_N <= 1'b1;
               if (!half_reg && (mask_reg[3:2] != 2'b00)) begin
                  half_reg   <= 1'b1;
                  SRAM_ADDR  <= half_addr(word_reg, 1'b1);
                  dq_out_reg <= wdata_reg[31:16];
                  state_reg  <= ST_WR_SETUP;
               end else begin
                  // Bus is released only after the hold cycle with WE_N high.
                  dq_oe_reg <= 1'b0;
                  SRAM_CE_N <= 1'b1;
                  o_ACK     <= 1'b1;
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Self-checking bench for sram_word_ctrl with a behavioural asynchronous SRAM model.
module tb_sram_word_ctrl;

   localparam int ACC = 2;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [17:0] i_ADDR;
   logic [31:0] i_WDATA;
   logic [3:0]  i_BMASK;
   logic        i_WREN;
   logic        i_RDEN;
   logic [31:0] o_RDATA;
   logic        o_ACK;
   logic [17:0] SRAM_ADDR;
   wire  [15:0] sram_dq;
   logic        SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N;

   int checks = 0;
   int errors = 0;
   int bus_viol = 0;

   logic [15:0] mem [0:1023];
   logic        mem_cleared = 1'b0;
   logic        bench_drive;

   always #5 clk = ~clk;

   sram_word_ctrl #(.ACC_CYC(ACC), .ADDR_W(18)) dut (
      .i_clk     (clk),
      .i_reset   (i_reset),
      .i_ADDR    (i_ADDR),
      .i_WDATA   (i_WDATA),
      .i_BMASK   (i_BMASK),
      .i_WREN    (i_WREN),
      .i_RDEN    (i_RDEN),
      .o_RDATA   (o_RDATA),
      .o_ACK     (o_ACK),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ   (sram_dq),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_LB_N (SRAM_LB_N),
      .SRAM_UB_N (SRAM_UB_N)
   );

   // SRAM read side: drive the bus while chip and output are enabled.
   assign bench_drive = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
   assign sram_dq = bench_drive ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;

   // SRAM write side and bus-protocol monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (i_reset && !mem_cleared) begin
         for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
         mem_cleared = 1'b1;
      end else if (!i_reset) begin
         if (!SRAM_CE_N && !SRAM_WE_N) begin
            if (!SRAM_LB_N) mem[SRAM_ADDR[9:0]][7:0]  = sram_dq[7:0];
            if (!SRAM_UB_N) mem[SRAM_ADDR[9:0]][15:8] = sram_dq[15:8];
         end
         if (!SRAM_OE_N && !SRAM_WE_N) bus_viol++;
         if (bench_drive && $isunknown(sram_dq)) bus_viol++;
      end
   end

   typedef struct {
      logic        wr;
      logic        rd;
      logic [17:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_we;
      int          exp_oe;
      logic [17:0] exp_addr;
      logic        exp_ce;
      logic [1:0]  exp_be;
   } vec_t;

   vec_t vecs [0:13];
   vec_t sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      vec_t        e;
      int          lat, we_cnt, oe_cnt;
      bit          seen, ce_seen;
      logic [17:0] a0;
      logic [1:0]  be;
      lat = 0; we_cnt = 0; oe_cnt = 0; seen = 0; ce_seen = 0; a0 = '0; be = 2'b11;
      @(posedge clk); #1;
      i_WREN = v.wr; i_RDEN = v.rd; i_ADDR = v.addr; i_WDATA = v.wdata; i_BMASK = v.mask;
      sb.push_back(v);
      for (int j = 0; j < 40 && !seen; j++) begin
         @(posedge clk); #1;
         if (!SRAM_WE_N) begin we_cnt++; be = {SRAM_UB_N, SRAM_LB_N}; end
         if (!SRAM_OE_N) oe_cnt++;
         if (!SRAM_CE_N && !ce_seen) begin ce_seen = 1; a0 = SRAM_ADDR; end
         if (o_ACK) begin
            seen = 1; lat = j + 1; i_WREN = 0; i_RDEN = 0;
         end else begin
            // Captured request must not follow later input changes.
            i_ADDR = ~v.addr; i_WDATA = ~v.wdata; i_BMASK = ~v.mask;
         end
      end
      e = sb.pop_front();
      if (!seen) begin
         checks++; errors++;
         $display("FAIL ack_timeout vec %0d: no o_ACK within 40 cycles", idx);
      end else begin
         check($sformatf("latency vec %0d", idx), lat, e.exp_lat);
         check($sformatf("rdata vec %0d", idx), o_RDATA, e.exp_rdata);
         check($sformatf("we_low vec %0d", idx), we_cnt, e.exp_we);
         check($sformatf("oe_low vec %0d", idx), oe_cnt, e.exp_oe);
         check($sformatf("ce_used vec %0d", idx), {31'b0, ce_seen}, {31'b0, e.exp_ce});
         if (e.exp_ce) check($sformatf("first_addr vec %0d", idx), {14'b0, a0}, {14'b0, e.exp_addr});
         if (e.exp_we > 0) check($sformatf("byte_lanes vec %0d", idx), {30'b0, be}, {30'b0, e.exp_be});
      end
      $display("txn %0d wr=%0b rd=%0b addr=%05h mask=%b lat=%0d rdata=%08h we=%0d oe=%0d",
               idx, v.wr, v.rd, v.addr, v.mask, lat, o_RDATA, we_cnt, oe_cnt);
   endtask

   initial begin
      int ack_pulses;
      //          wr  rd  addr       wdata         mask     exp_rdata     lat we oe addr      ce   be
      vecs[0]  = '{1'b1, 1'b0, 18'h00104, 32'hDEADBEEF, 4'b1111, 32'h00000000, 9, 4, 0, 18'h00082, 1'b1, 2'b00};
      vecs[1]  = '{1'b0, 1'b1, 18'h00104, 32'h00000000, 4'b0000, 32'hDEADBEEF, 5, 0, 4, 18'h00082, 1'b1, 2'b00};
      vecs[2]  = '{1'b1, 1'b0, 18'h00104, 32'h00AA0000, 4'b0100, 32'hDEADBEEF, 5, 2, 0, 18'h00083, 1'b1, 2'b10};
      vecs[3]  = '{1'b0, 1'b1, 18'h00104, 32'h00000000, 4'b0000, 32'hDEAABEEF, 5, 0, 4, 18'h00082, 1'b1, 2'b00};
      vecs[4]  = '{1'b1, 1'b0, 18'h00200, 32'hFFFFFFFF, 4'b0000, 32'hDEAABEEF, 1, 0, 0, 18'h00000, 1'b0, 2'b00};
      vecs[5]  = '{1'b1, 1'b1, 18'h00208, 32'h12345678, 4'b1111, 32'hDEAABEEF, 9, 4, 0, 18'h00104, 1'b1, 2'b00};
      vecs[6]  = '{1'b0, 1'b1, 18'h00208, 32'h00000000, 4'b0000, 32'h12345678, 5, 0, 4, 18'h00104, 1'b1, 2'b00};
      vecs[7]  = '{1'b1, 1'b0, 18'h00010, 32'h0000CAFE, 4'b0011, 32'h12345678, 5, 2, 0, 18'h00008, 1'b1, 2'b00};
      vecs[8]  = '{1'b0, 1'b1, 18'h00010, 32'h00000000, 4'b0000, 32'h0000CAFE, 5, 0, 4, 18'h00008, 1'b1, 2'b00};
      vecs[9]  = '{1'b1, 1'b0, 18'h3FFFC, 32'hA5A55A5A, 4'b1111, 32'h0000CAFE, 9, 4, 0, 18'h1FFFE, 1'b1, 2'b00};
      vecs[10] = '{1'b0, 1'b1, 18'h3FFFC, 32'h00000000, 4'b0000, 32'hA5A55A5A, 5, 0, 4, 18'h1FFFE, 1'b1, 2'b00};
      vecs[11] = '{1'b1, 1'b0, 18'h00104, 32'h11000000, 4'b1000, 32'hA5A55A5A, 5, 2, 0, 18'h00083, 1'b1, 2'b01};
      vecs[12] = '{1'b0, 1'b1, 18'h00104, 32'h00000000, 4'b0000, 32'h11AABEEF, 5, 0, 4, 18'h00082, 1'b1, 2'b00};
      vecs[13] = '{1'b1, 1'b0, 18'h00014, 32'h0000BEEF, 4'b0001, 32'h11AABEEF, 5, 2, 0, 18'h0000A, 1'b1, 2'b10};

      i_reset = 1'b1; i_ADDR = '0; i_WDATA = '0; i_BMASK = '0; i_WREN = 1'b0; i_RDEN = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ack", {31'b0, o_ACK}, 32'd0);
      check("reset rdata", o_RDATA, 32'd0);
      check("reset ctrl", {27'b0, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N}, 32'h1F);
      check("reset addr", {14'b0, SRAM_ADDR}, 32'd0);
      check("reset dq_z", {31'b0, (sram_dq === 16'hzzzz)}, 32'd1);
      i_reset = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

      // Reset in the middle of a read: no ack, read data cleared, pins idle.
      ack_pulses = 0;
      @(posedge clk); #1;
      i_RDEN = 1'b1; i_ADDR = 18'h00104;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (o_ACK) ack_pulses++;
      i_reset = 1'b1; i_RDEN = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         if (o_ACK) ack_pulses++;
      end
      i_reset = 1'b0;
      check("midread rdata", o_RDATA, 32'd0);
      check("midread ctrl", {27'b0, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N}, 32'h1F);
      check("midread dq_z", {31'b0, (sram_dq === 16'hzzzz)}, 32'd1);
      check("midread addr", {14'b0, SRAM_ADDR}, 32'd0);
      for (int j = 0; j < 6; j++) begin
         @(posedge clk); #1;
         if (o_ACK) ack_pulses++;
      end
      check("midread no_ack", ack_pulses, 32'd0);
      $display("txn reset-mid-read ack_pulses=%0d rdata=%08h", ack_pulses, o_RDATA);

      // Controller recovers and reads the untouched memory.
      run_vec(14, vecs[12]);

      check("bus_protocol", bus_viol, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
